// File: rtl/joy_port_map_pkg.sv
// Shared definitions for the joystick-to-ZX port mapper: mode encodings,
// default port addresses, bus widths and the pad vector bit layout.
package joy_port_map_pkg;

  typedef enum logic [1:0] {
    JMODE_KEMPSTON  = 2'd0,
    JMODE_SINCLAIR1 = 2'd1,
    JMODE_SINCLAIR2 = 2'd2,
    JMODE_CURSOR    = 2'd3
  } jmode_e;

  localparam logic [7:0] KEMPSTON_PORT_DEF = 8'h1F;
  localparam logic [7:0] CFG_PORT_DEF      = 8'hF7;

  localparam int ZX_ADDR_W = 16;
  localparam int ZX_DATA_W = 8;
  localparam int KB_W      = 5;
  localparam int CFG_W     = 3;

  // Bit positions inside the 12-bit pad vector
  localparam int PAD_W     = 12;
  localparam int PAD_UP    = 0;
  localparam int PAD_DOWN  = 1;
  localparam int PAD_LEFT  = 2;
  localparam int PAD_RIGHT = 3;
  localparam int PAD_B1    = 4;
  localparam int PAD_B2    = 5;
  localparam int PAD_B3    = 6;
  localparam int PAD_X     = 7;
  localparam int PAD_Y     = 8;
  localparam int PAD_Z     = 9;
  localparam int PAD_START = 10;
  localparam int PAD_MODE  = 11;

  // Field order matches the Kempston byte, bit7..bit0
  typedef struct packed {
    logic start;
    logic fire3;
    logic fire2;
    logic fire1;
    logic up;
    logic down;
    logic left;
    logic right;
  } joy_keys_t;

  // Key presses for the half-rows A11 (keys 1-5) and A12 (keys 0-6).
  // A row only contributes when the CPU is scanning it.
  function automatic logic [KB_W-1:0] kb_map(input jmode_e    mode,
                                             input joy_keys_t k,
                                             input logic      row11_sel,
                                             input logic      row12_sel);
    logic [KB_W-1:0] r11;
    logic [KB_W-1:0] r12;
    r11 = '0;
    r12 = '0;
    case (mode)
      JMODE_SINCLAIR1: r12 = {k.left, k.right, k.down, k.up, k.fire1};
      JMODE_SINCLAIR2: r11 = {k.fire1, k.up, k.down, k.right, k.left};
      JMODE_CURSOR: begin
        r11 = {k.left, 4'b0000};
        r12 = {k.down, k.up, k.right, 1'b0, k.fire1};
      end
      default: ;
    endcase
    return (row11_sel ? r11 : '0) | (row12_sel ? r12 : '0);
  endfunction

endpackage

// File: rtl/joy_port_map_if.sv
// Z80 I/O bus view seen by the joystick mapper. The CPU side is the master,
// the mapper is the slave that returns read data and keyboard presses.
interface joy_port_map_if;
  import joy_port_map_pkg::*;

  logic [ZX_ADDR_W-1:0] bus_a;
  logic [ZX_DATA_W-1:0] bus_d;
  logic                 bus_iord;
  logic                 bus_iowr;
  logic [ZX_DATA_W-1:0] d_out;
  logic                 d_out_oe;
  logic [KB_W-1:0]      kb_press;

  modport master (
    output bus_a, bus_d, bus_iord, bus_iowr,
    input  d_out, d_out_oe, kb_press
  );

  modport slave (
    input  bus_a, bus_d, bus_iord, bus_iowr,
    output d_out, d_out_oe, kb_press
  );

endinterface

// File: rtl/joy_port_map_filter2.sv
// Two-sample equality filter: a vector sampled on snap_i is only accepted
// once the same value has been seen on two consecutive snapshots.
module joy_filter2 #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         snap_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] raw_o,
  output logic [W-1:0] stable_o
);

  logic [W-1:0] raw_q, raw_d;
  logic [W-1:0] stable_q, stable_d;

  // Next-state: capture on snapshot, accept when it repeats the last one
  always_comb begin
    raw_d    = raw_q;
    stable_d = stable_q;
    if (snap_i) begin
      raw_d = din_i;
      if (din_i == raw_q) begin
        stable_d = din_i;
      end
    end
  end

  // Snapshot and filtered state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q    <= '0;
      stable_q <= '0;
    end else begin
      raw_q    <= raw_d;
      stable_q <= stable_d;
    end
  end

  assign raw_o    = raw_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/joy_port_map.sv
// Sega pad to ZX I/O mapper: Kempston port or Sinclair/Cursor key injection,
// selected by a 3-bit config register written over the Z80 I/O bus.
module joy_port_map
  import joy_port_map_pkg::*;
#(
  parameter logic [7:0] KEMPSTON_PORT = KEMPSTON_PORT_DEF,
  parameter logic [7:0] CFG_PORT      = CFG_PORT_DEF
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic [8:0] vc,
  input  logic [8:0] hc,
  input  logic       turbo_strobe,
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic       joy_b1,
  input  logic       joy_b2,
  input  logic       joy_b3,
  input  logic       joy_x,
  input  logic       joy_y,
  input  logic       joy_z,
  input  logic       joy_start,
  input  logic       joy_mode,
  joy_port_map_if.slave bus
);

  // First cycle after the pad reader's window closes, once per read period
  logic snap;
  assign snap = (vc[6:0] == 7'd0) && (hc == 9'd256);

  logic [PAD_W-1:0] pad_vec;
  logic [PAD_W-1:0] pad_raw;
  logic [PAD_W-1:0] pad_stable;

  assign pad_vec[PAD_UP]    = joy_up;
  assign pad_vec[PAD_DOWN]  = joy_down;
  assign pad_vec[PAD_LEFT]  = joy_left;
  assign pad_vec[PAD_RIGHT] = joy_right;
  assign pad_vec[PAD_B1]    = joy_b1;
  assign pad_vec[PAD_B2]    = joy_b2;
  assign pad_vec[PAD_B3]    = joy_b3;
  assign pad_vec[PAD_X]     = joy_x;
  assign pad_vec[PAD_Y]     = joy_y;
  assign pad_vec[PAD_Z]     = joy_z;
  assign pad_vec[PAD_START] = joy_start;
  assign pad_vec[PAD_MODE]  = joy_mode;

  joy_filter2 #(
    .W (PAD_W)
  ) u_filter (
    .clk_i    (clk28),
    .rst_i    (rst),
    .snap_i   (snap),
    .din_i    (pad_vec),
    .raw_o    (pad_raw),
    .stable_o (pad_stable)
  );

  // ---------------------------------------------------------------------
  // Config register, written once per bus cycle on the iowr rising edge
  // ---------------------------------------------------------------------
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             iowr_q, iowr_d;
  logic             cfg_wr;

  assign cfg_wr = bus.bus_iowr && !iowr_q && (bus.bus_a[7:0] == CFG_PORT);

  // Next-state for config and write-strobe edge detector
  always_comb begin
    iowr_d = bus.bus_iowr;
    cfg_d  = cfg_q;
    if (cfg_wr) begin
      cfg_d = bus.bus_d[CFG_W-1:0];
    end
  end

  // Config and edge-detect registers
  always_ff @(posedge clk28) begin
    if (rst) begin
      cfg_q  <= '0;
      iowr_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      iowr_q <= iowr_d;
    end
  end

  jmode_e mode;
  logic   turbo_en;

  assign mode     = jmode_e'(cfg_q[1:0]);
  assign turbo_en = cfg_q[2];

  // ---------------------------------------------------------------------
  // Button mapping with optional autofire on X/Y/Z
  // ---------------------------------------------------------------------
  joy_keys_t keys;

  // Turbo folds Y/Z/X onto fire1/2/3 gated by the autofire square wave
  always_comb begin
    keys.start = pad_stable[PAD_START];
    keys.up    = pad_stable[PAD_UP];
    keys.down  = pad_stable[PAD_DOWN];
    keys.left  = pad_stable[PAD_LEFT];
    keys.right = pad_stable[PAD_RIGHT];
    keys.fire1 = pad_stable[PAD_B1] | (turbo_en & pad_stable[PAD_Y] & turbo_strobe);
    keys.fire2 = pad_stable[PAD_B2] | (turbo_en & pad_stable[PAD_Z] & turbo_strobe);
    keys.fire3 = pad_stable[PAD_B3] | (turbo_en & pad_stable[PAD_X] & turbo_strobe);
  end

  // ---------------------------------------------------------------------
  // Read decode and registered bus outputs
  // ---------------------------------------------------------------------
  logic sel_kemp;
  logic sel_cfg;

  assign sel_kemp = bus.bus_iord && (bus.bus_a[7:0] == KEMPSTON_PORT) &&
                    (mode == JMODE_KEMPSTON);
  assign sel_cfg  = bus.bus_iord && (bus.bus_a[7:0] == CFG_PORT);

  logic [ZX_DATA_W-1:0] d_out_q, d_out_d;
  logic                 oe_q, oe_d;
  logic [KB_W-1:0]      kb_q, kb_d;

  // Output next-state from the current address/strobe and mapped buttons
  always_comb begin
    d_out_d = '0;
    oe_d    = 1'b0;
    if (sel_kemp) begin
      oe_d    = 1'b1;
      d_out_d = keys;
    end else if (sel_cfg) begin
      oe_d    = 1'b1;
      d_out_d = {{(ZX_DATA_W-CFG_W){1'b0}}, cfg_q};
    end
    kb_d = kb_map(mode, keys, !bus.bus_a[11], !bus.bus_a[12]);
  end

  // Registered outputs so the bus never sees intra-cycle glitches
  always_ff @(posedge clk28) begin
    if (rst) begin
      d_out_q <= '0;
      oe_q    <= 1'b0;
      kb_q    <= '0;
    end else begin
      d_out_q <= d_out_d;
      oe_q    <= oe_d;
      kb_q    <= kb_d;
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.d_out_oe = oe_q;
  assign bus.kb_press = kb_q;

  // Inputs and state that the mapping deliberately does not use
  logic unused_ok;
  assign unused_ok = ^{bus.bus_d[ZX_DATA_W-1:CFG_W], vc[8:7], pad_raw,
                       pad_stable[PAD_MODE]};

endmodule

// File: doc/joy_port_map.md
# joy_port_map

Maps the decoded Sega pad state onto the ZX I/O bus as a Kempston port or Sinclair/Cursor keyboard presses, selected by a writable config register. Sits directly downstream of the Sega pad reader:
- consumes its per-button levels;
- snapshots them once per pad read cycle, using the shared `vc`/`hc` counters;
- filters them over two snapshots;
- applies turbo;
- serves Z80 I/O reads.

## Interface
- `KEMPSTON_PORT`, 8'h1F: low address byte of the Kempston read port.
- `CFG_PORT`, 8'hF7: low address byte of the config read/write port.

Ports:
- `clk28` in 1: system clock. One clock `clk28`; reset `rst` synchronous, active-high.
- `rst` in 1: synchronous active-high reset.
- `vc` in 9: video line counter.
- `hc` in 9: video pixel counter.
- `turbo_strobe` in 1: autofire square wave.
- `joy_up`, `joy_down`, `joy_left`, `joy_right`, `joy_b1`, `joy_b2`, `joy_b3`, `joy_x`, `joy_y`, `joy_z`, `joy_start`, `joy_mode` in 1 each: active-high pad levels from the pad reader.
- `bus_a` in 16: Z80 address.
- `bus_d` in 8: Z80 write data.
- `bus_iord` in 1: I/O read cycle active.
- `bus_iowr` in 1: I/O write cycle active.
- `d_out` out 8: read data.
- `d_out_oe` out 1: this block drives the data bus.
- `kb_press` out 5: active-high key presses for the keyboard half-row currently addressed by `bus_a[15:8]`; ORed into the port #FE result by the consumer.

## Operation
Snapshot:
- `snap` is high for exactly one `clk28` when `vc[6:0]==0 && hc==9'd256`.
- This is the first cycle after the pad reader's window closes.
- On `snap`, the 12 pad bits are captured into `raw_q`.

Filter:
- On `snap`, if the incoming 12-bit vector equals `raw_q`, `stable_q` takes the vector.
- Otherwise `stable_q` is unchanged.
- A change is therefore accepted after two consecutive equal samples, which is at most 2 read periods (~16 ms) of latency.

Turbo (combinational from `stable_q` and `turbo_strobe`, only when `cfg[2]`):
- fire1 = b1 | (y & ts)
- fire2 = b2 | (z & ts)
- fire3 = b3 | (x & ts)
- When `cfg[2]==0`, fireN is the plain button, and x/y/z are ignored.

Config register `cfg[2:0]`:
- Written from `bus_d[2:0]` on the rising edge of `bus_iowr` when `bus_a[7:0]==CFG_PORT`; the edge is detected against the previous-cycle `bus_iowr`.
- One write per bus cycle.
- Bits [1:0] select the mode:
  - 0: Kempston
  - 1: Sinclair-1 (keys 6-0)
  - 2: Sinclair-2 (keys 1-5)
  - 3: Cursor
- Bit 2 is turbo enable.

Reads:
- Kempston port: `bus_iord && bus_a[7:0]==KEMPSTON_PORT && mode==0`. Returns {start, fire3, fire2, fire1, up, down, left, right}, bit7..bit0.
- Config port: `bus_iord && bus_a[7:0]==CFG_PORT`. Returns {5'b0, cfg}.
- Any other access: `d_out_oe=0` and `d_out=0`.

Keyboard injection (mode ≠ 0; bit0..4 of each half-row as on the ZX):
- Sinclair-1, row A12: right→bit3, left→bit4, down→bit2, up→bit1, fire1→bit0.
- Sinclair-2, row A11: left→bit0, right→bit1, down→bit2, up→bit3, fire1→bit4.
- Cursor:
  - row A11: left→bit4 (key 5);
  - row A12: down→bit4 (key 6), up→bit3 (key 7), right→bit2 (key 8), fire1→bit0 (key 0).
- A row contributes to `kb_press` when its address bit (`bus_a[11]` or `bus_a[12]`) is 0.
- With both rows addressed, the contributions are ORed.
- In mode 0, `kb_press=0`.

## Timing
- `d_out`, `d_out_oe` and `kb_press` are registered: valid one `clk28` after the address/strobe condition holds, and they follow it each cycle.
- They drop one cycle after `bus_iord` falls or the address changes.
- A `cfg` write takes effect on the cycle after the `bus_iowr` rising edge, and mapping outputs reflect the new mode one cycle later.
- When `snap` coincides with an active read, the registered output updates on the next cycle. No glitch within a cycle.
- Reset values:
  - `cfg=0`, `raw_q=0`, `stable_q=0`;
  - `d_out=0`, `d_out_oe=0`, `kb_press=0`;
  - edge-detect register 0.
- Reset asserted mid-read forces `d_out_oe=0` on the next edge.
- A write while `rst` is high is ignored.

## Structure
- Shared package: the mode encodings (`JMODE_KEMPSTON` … `JMODE_CURSOR`), default port constants, and the 12-bit pad vector bit indices.
- One natural sub-module, `joy_filter2`: the snapshot and two-sample equality filter, parameterised by width.
- Decode, config and mapping logic live in the top.

## Test plan
1. Reset, then a Kempston read of port #001F with no buttons → `d_out_oe=1`, `d_out=8'h00`. Reading port #00FE → `d_out_oe=0`.
2. Hold `joy_right` and `joy_b1` across two `snap` pulses, then read #1F → 8'h11 after the 2nd snap and 8'h00 after only the 1st. A one-sample glitch never appears.
3. Write `cfg=3'b001`, hold `joy_left`, and read with `bus_a=16'hEFFE` → `kb_press=5'b10000`. With `bus_a=16'hF7FE` → `kb_press=0`. Port #1F is now undriven.
4. Write `cfg=3'b011`, hold `joy_left`, `joy_up` and `joy_b1`, and read with `bus_a=16'hE7FE` → `kb_press=5'b11001`.
5. Write `cfg=3'b100`, hold `joy_y`, toggle `turbo_strobe`, and read #1F → bit4 follows `turbo_strobe`. With `cfg=3'b000`, bit4 stays 0.
6. Write `cfg=3'b110` with `bus_iowr` held high for 10 cycles, then read #F7 → 8'h06. Assert `rst` mid-read → `d_out_oe=0` the next cycle and `cfg` is back to 0.
